// File: rtl/uart_pkg.sv
// uart_pkg: baud encodings, oversample divisors and receiver state type shared by the UART blocks
package uart_pkg;
    localparam logic [1:0] BAUD48  = 2'd0;
    localparam logic [1:0] BAUD96  = 2'd1;
    localparam logic [1:0] BAUD192 = 2'd2;
    localparam logic [1:0] BAUD384 = 2'd3;
    localparam int DIV_W = 9;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    // clk cycles per oversample tick at 36 MHz
    function automatic logic [DIV_W-1:0] os_div(input logic [1:0] baud_rate);
        return baud_rate == BAUD48  ? 9'd469 :
               baud_rate == BAUD96  ? 9'd234 :
               baud_rate == BAUD192 ? 9'd117 : 9'd59;
    endfunction
endpackage

// File: rtl/uart_rx_tick.sv
// uart_rx_tick: oversample divider, pulses tick once every os_div(baud_rate) clocks
module uart_rx_tick
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       clr,
    input  logic [1:0] baud_rate,
    output logic       tick
);
    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick  = !clr && (cnt_q == os_div(baud_rate) - 1'b1);
    assign cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 16x oversampling, valid/ready output, framing and overrun flags
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [1:0]           baud_rate,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] MID   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

    logic                 rx_meta_q, rx_s_q, rx_prev_q;
    rx_state_t            state_q, state_d;
    logic [1:0]           baud_q, baud_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic                 start_det, tick, stop_ok, stop_bad, deliver;

    assign start_det = (state_q == IDLE) && rx_prev_q && !rx_s_q;
    assign baud_d    = start_det ? baud_rate : baud_q;

    uart_rx_tick u_tick (
        .clk       (clk),
        .resetn    (resetn),
        .clr       (start_det),
        .baud_rate (baud_q),
        .tick      (tick)
    );

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        bcnt_d   = bcnt_q;
        shift_d  = shift_q;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        case (state_q)
            IDLE: if (start_det) begin
                state_d = START;
                tcnt_d  = '0;
            end
            START: if (tick) begin
                tcnt_d = tcnt_q + 1'b1;
                if (tcnt_q == MID) begin
                    state_d = rx_s_q ? IDLE : DATA;
                    tcnt_d  = '0;
                    bcnt_d  = '0;
                end
            end
            DATA: if (tick) begin
                tcnt_d = tcnt_q + 1'b1;
                if (tcnt_q == LAST) begin
                    tcnt_d  = '0;
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    bcnt_d  = bcnt_q + 1'b1;
                    state_d = (bcnt_q == BLAST) ? STOP : DATA;
                end
            end
            STOP: if (tick) begin
                tcnt_d = tcnt_q + 1'b1;
                if (tcnt_q == LAST) begin
                    tcnt_d   = '0;
                    state_d  = IDLE;
                    stop_ok  = rx_s_q;
                    stop_bad = !rx_s_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // a completed byte lands only if the holding register is free or being drained this cycle
    assign deliver     = stop_ok && (!rx_valid_q || rx_ready);
    assign rx_data_d   = deliver ? shift_q : rx_data_q;
    assign rx_valid_d  = deliver || (rx_valid_q && !rx_ready);
    assign frame_err_d = stop_bad;
    assign overrun_d   = stop_ok && !deliver;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= IDLE;
            baud_q      <= '0;
            tcnt_q      <= '0;
            bcnt_q      <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            rx_prev_q   <= rx_s_q;
            state_q     <= state_d;
            baud_q      <= baud_d;
            tcnt_q      <= tcnt_d;
            bcnt_q      <= bcnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scenario bench for uart_rx
module tb_uart_rx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [1:0] baud_rate = 2'd0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun;

    int cmp_n = 0, err_n = 0;
    int cyc = 0, vld_rise = 0, vld_hi = 0, fe_n = 0, ov_n = 0, both_n = 0, data_n = 0, rise_cyc = 0;
    logic v_prev = 1'b0;
    int div_tab [4] = '{469, 234, 117, 59};

    uart_rx dut (
        .clk       (clk),
        .resetn    (resetn),
        .baud_rate (baud_rate),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #14 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid && !v_prev) begin
            vld_rise++;
            rise_cyc = cyc;
        end
        if (rx_valid) vld_hi++;
        if (frame_err) fe_n++;
        if (overrun) ov_n++;
        if (frame_err && overrun) both_n++;
        if (dut.state_q == DATA) data_n++;
        v_prev = rx_valid;
    end

    function automatic int bit_per(input int b, input int skew);
        return 16 * div_tab[b] * (100 + skew) / 100;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int per);
        rx = 1'b0;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (per) @(negedge clk);
        end
        rx = stop_bit;
        repeat (per) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        cmp_n++; if (rx_data !== 8'h00) begin err_n++; $display("FAIL reset_data: got %h expected 00", rx_data); end
        cmp_n++; if (rx_valid !== 1'b0) begin err_n++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
        cmp_n++; if (frame_err !== 1'b0) begin err_n++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        cmp_n++; if (overrun !== 1'b0) begin err_n++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        cmp_n++; if (dut.state_q !== IDLE) begin err_n++; $display("FAIL reset_state: got %0d expected 0", dut.state_q); end
        resetn = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic;
        int v0, h0, f0, o0, c0, lat, exp_lat;
        baud_rate = 2'd1;
        rx_ready  = 1'b1;
        v0 = vld_rise; h0 = vld_hi; f0 = fe_n; o0 = ov_n;
        c0 = cyc;
        send_frame(8'hA5, 1'b1, bit_per(1, 0));
        repeat (300) @(negedge clk);
        lat = rise_cyc - c0;
        exp_lat = 152 * div_tab[1] + 3;
        cmp_n++; if (rx_data !== 8'hA5) begin err_n++; $display("FAIL basic_data: got %h expected a5", rx_data); end
        cmp_n++; if (vld_rise - v0 != 1) begin err_n++; $display("FAIL basic_valid_count: got %0d expected 1", vld_rise - v0); end
        cmp_n++; if (vld_hi - h0 != 1) begin err_n++; $display("FAIL basic_valid_len: got %0d expected 1", vld_hi - h0); end
        cmp_n++; if (fe_n - f0 != 0) begin err_n++; $display("FAIL basic_frame_err: got %0d expected 0", fe_n - f0); end
        cmp_n++; if (ov_n - o0 != 0) begin err_n++; $display("FAIL basic_overrun: got %0d expected 0", ov_n - o0); end
        cmp_n++; if (lat < exp_lat - 2 || lat > exp_lat + 2) begin err_n++; $display("FAIL basic_latency: got %0d expected %0d", lat, exp_lat); end
    endtask

    task automatic test_back_to_back;
        int v0, f0, o0;
        baud_rate = 2'd3;
        rx_ready  = 1'b0;
        v0 = vld_rise; f0 = fe_n; o0 = ov_n;
        send_frame(8'h00, 1'b1, bit_per(3, 2));
        send_frame(8'hFF, 1'b1, bit_per(3, 2));
        repeat (200) @(negedge clk);
        cmp_n++; if (rx_data !== 8'h00) begin err_n++; $display("FAIL b2b_data: got %h expected 00", rx_data); end
        cmp_n++; if (rx_valid !== 1'b1) begin err_n++; $display("FAIL b2b_valid: got %b expected 1", rx_valid); end
        cmp_n++; if (ov_n - o0 != 1) begin err_n++; $display("FAIL b2b_overrun: got %0d expected 1", ov_n - o0); end
        cmp_n++; if (fe_n - f0 != 0) begin err_n++; $display("FAIL b2b_frame_err: got %0d expected 0", fe_n - f0); end
        cmp_n++; if (vld_rise - v0 != 1) begin err_n++; $display("FAIL b2b_valid_count: got %0d expected 1", vld_rise - v0); end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        cmp_n++; if (rx_valid !== 1'b0) begin err_n++; $display("FAIL b2b_consume: got %b expected 0", rx_valid); end
        cmp_n++; if (rx_data !== 8'h00) begin err_n++; $display("FAIL b2b_data_after: got %h expected 00", rx_data); end
    endtask

    task automatic test_frame_err;
        int v0, f0, o0;
        baud_rate = 2'd3;
        rx_ready  = 1'b1;
        v0 = vld_rise; f0 = fe_n; o0 = ov_n;
        send_frame(8'h3C, 1'b0, bit_per(3, -2));
        repeat (100) @(negedge clk);
        cmp_n++; if (fe_n - f0 != 1) begin err_n++; $display("FAIL ferr_pulse: got %0d expected 1", fe_n - f0); end
        cmp_n++; if (vld_rise - v0 != 0) begin err_n++; $display("FAIL ferr_valid: got %0d expected 0", vld_rise - v0); end
        cmp_n++; if (rx_data !== 8'h00) begin err_n++; $display("FAIL ferr_data_kept: got %h expected 00", rx_data); end
        send_frame(8'h55, 1'b1, bit_per(3, -2));
        repeat (200) @(negedge clk);
        cmp_n++; if (rx_data !== 8'h55) begin err_n++; $display("FAIL ferr_next_data: got %h expected 55", rx_data); end
        cmp_n++; if (vld_rise - v0 != 1) begin err_n++; $display("FAIL ferr_next_valid: got %0d expected 1", vld_rise - v0); end
        cmp_n++; if (fe_n - f0 != 1) begin err_n++; $display("FAIL ferr_next_clean: got %0d expected 1", fe_n - f0); end
        cmp_n++; if (ov_n - o0 != 0) begin err_n++; $display("FAIL ferr_overrun: got %0d expected 0", ov_n - o0); end
    endtask

    task automatic test_glitch;
        int v0, f0, d0;
        baud_rate = 2'd3;
        v0 = vld_rise; f0 = fe_n; d0 = data_n;
        rx = 1'b0;
        repeat (4 * div_tab[3]) @(negedge clk);
        rx = 1'b1;
        repeat (16 * div_tab[3]) @(negedge clk);
        cmp_n++; if (data_n - d0 != 0) begin err_n++; $display("FAIL glitch_no_data: got %0d expected 0", data_n - d0); end
        cmp_n++; if (vld_rise - v0 != 0) begin err_n++; $display("FAIL glitch_valid: got %0d expected 0", vld_rise - v0); end
        cmp_n++; if (fe_n - f0 != 0) begin err_n++; $display("FAIL glitch_frame_err: got %0d expected 0", fe_n - f0); end
        cmp_n++; if (dut.state_q !== IDLE) begin err_n++; $display("FAIL glitch_state: got %0d expected 0", dut.state_q); end
    endtask

    task automatic test_reset_midframe;
        int per, v0, f0;
        logic [7:0] d;
        d = 8'h81;
        per = bit_per(3, 0);
        baud_rate = 2'd3;
        rx = 1'b0;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (per) @(negedge clk);
        end
        rx = d[4];
        repeat (per / 2) @(negedge clk);
        cmp_n++; if (dut.state_q !== DATA) begin err_n++; $display("FAIL rstmid_in_data: got %0d expected 2", dut.state_q); end
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        cmp_n++; if (rx_data !== 8'h00) begin err_n++; $display("FAIL rstmid_data: got %h expected 00", rx_data); end
        cmp_n++; if (rx_valid !== 1'b0) begin err_n++; $display("FAIL rstmid_valid: got %b expected 0", rx_valid); end
        cmp_n++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin err_n++; $display("FAIL rstmid_flags: got %b%b expected 00", frame_err, overrun); end
        cmp_n++; if (dut.state_q !== IDLE) begin err_n++; $display("FAIL rstmid_state: got %0d expected 0", dut.state_q); end
        rx = 1'b1;
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        v0 = vld_rise; f0 = fe_n;
        fork
            send_frame(8'h81, 1'b1, bit_per(3, 2));
            begin
                repeat (3 * per) @(negedge clk);
                baud_rate = 2'd0;
            end
        join
        repeat (200) @(negedge clk);
        cmp_n++; if (rx_data !== 8'h81) begin err_n++; $display("FAIL rstmid_next_data: got %h expected 81", rx_data); end
        cmp_n++; if (vld_rise - v0 != 1) begin err_n++; $display("FAIL rstmid_next_valid: got %0d expected 1", vld_rise - v0); end
        cmp_n++; if (fe_n - f0 != 0) begin err_n++; $display("FAIL rstmid_next_ferr: got %0d expected 0", fe_n - f0); end
        baud_rate = 2'd3;
    endtask

    task automatic test_baud_rates;
        int c0, lat;
        for (int b = 0; b < 4; b++) begin
            baud_rate = b[1:0];
            repeat (2) @(negedge clk);
            rx = 1'b0;
            c0 = cyc;
            repeat (3) @(negedge clk);
            for (int k = 0; k < 1000 && !dut.u_tick.tick; k++) @(negedge clk);
            lat = cyc - c0;
            cmp_n++; if (lat != div_tab[b] + 2) begin err_n++; $display("FAIL baud%0d_tick: got %0d expected %0d", b, lat, div_tab[b] + 2); end
            cmp_n++; if (dut.state_q !== START) begin err_n++; $display("FAIL baud%0d_state: got %0d expected 1", b, dut.state_q); end
            resetn = 1'b0;
            @(negedge clk);
            rx = 1'b1;
            resetn = 1'b1;
            repeat (5) @(negedge clk);
        end
        cmp_n++; if (both_n != 0) begin err_n++; $display("FAIL flags_exclusive: got %0d expected 0", both_n); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_reset_midframe();
        test_baud_rates();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end
endmodule
